// File: rtl/pp_pkg.sv
// Shared definitions for the peak-to-peak measurement scheduler:
// one-hot FSM encoding and the result width.
package pp_pkg;
  localparam int VPP_W = 33;

  typedef enum logic [4:0] {
    S_IDLE  = 5'b00001,
    S_START = 5'b00010,
    S_WAIT  = 5'b00100,
    S_ACC   = 5'b01000,
    S_DONE  = 5'b10000
  } state_e;
endpackage

// File: rtl/pp_avg_acc.sv
// Accumulates per-window (max-min) and (max+min), and averages them over
// 2^AVG_LOG2 windows. Windows with max<min are flagged and contribute 0.
module pp_avg_acc
  import pp_pkg::*;
#(
  parameter int AVG_LOG2 = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_clr,
  input  logic                    i_add,
  input  logic signed [31:0]      i_max,
  input  logic signed [31:0]      i_min,
  output logic                    o_range_hit,
  output logic [VPP_W-1:0]        o_vpp,
  output logic signed [31:0]      o_offset
);
  localparam int AW = VPP_W + AVG_LOG2;

  logic [AW-1:0]          vpp_acc_q, vpp_acc_d;
  logic signed [AW-1:0]   mid_acc_q, mid_acc_d;
  logic signed [VPP_W-1:0] max_x, min_x, diff, sum;

  always_comb begin
    max_x       = {i_max[31], i_max};
    min_x       = {i_min[31], i_min};
    diff        = max_x - min_x;
    sum         = max_x + min_x;
    o_range_hit = (i_max < i_min);
    vpp_acc_d   = vpp_acc_q;
    mid_acc_d   = mid_acc_q;
    if (i_clr) begin
      vpp_acc_d = '0;
      mid_acc_d = '0;
    end else if (i_add && !o_range_hit) begin
      // diff is non-negative here, so zero extension is exact
      vpp_acc_d = vpp_acc_q + AW'($unsigned(diff));
      mid_acc_d = mid_acc_q + AW'(sum);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vpp_acc_q <= '0;
      mid_acc_q <= '0;
    end else begin
      vpp_acc_q <= vpp_acc_d;
      mid_acc_q <= mid_acc_d;
    end
  end

  // Extra shift on mid folds the /2 of (max+min)/2 into the average.
  assign o_vpp    = VPP_W'(vpp_acc_q >> AVG_LOG2);
  assign o_offset = 32'(mid_acc_q >>> (AVG_LOG2 + 1));
endmodule

// File: rtl/pp_sched.sv
// Peak-to-peak measurement scheduler: runs 2^AVG_LOG2 search windows on an
// external peak-search engine and reports averaged vpp and offset.
// Optional WAIT timeout is built when PP_SCHED_TIMEOUT_EN is defined.
module pp_sched
  import pp_pkg::*;
#(
  parameter int AVG_LOG2       = 2,
  parameter int TIMEOUT_MARGIN = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [31:0]         i_cfg_search_time,
  input  logic                i_cfg_continuous,
  input  logic                i_arm,
  input  logic                i_abort,
  output logic                o_search_start_pulse,
  output logic [31:0]         o_search_time,
  input  logic signed [31:0]  i_search_max,
  input  logic signed [31:0]  i_search_min,
  input  logic                i_search_end_pulse,
  output logic [VPP_W-1:0]    o_vpp,
  output logic signed [31:0]  o_offset,
  output logic                o_result_valid,
  output logic                o_busy,
  output logic                o_timeout,
  output logic                o_range_err
);
  localparam int CW = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam logic [CW-1:0] LAST = CW'((1 << AVG_LOG2) - 1);

  state_e              state_q, state_d;
  logic [31:0]         st_q, st_d;
  logic                cont_q, cont_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic signed [31:0]  max_q, max_d, min_q, min_d;
  logic [VPP_W-1:0]    vpp_q, vpp_d;
  logic signed [31:0]  offset_q, offset_d;
  logic                range_err_q, range_err_d;
  logic                acc_clr, acc_add, done_fire, start_pulse, range_hit;
  logic [VPP_W-1:0]    avg_vpp;
  logic signed [31:0]  avg_offset;
`ifdef PP_SCHED_TIMEOUT_EN
  logic [32:0]         wait_cnt_q, wait_cnt_d, wait_limit;
  logic                timeout_q, timeout_d;
`endif

  pp_avg_acc #(.AVG_LOG2(AVG_LOG2)) u_acc (
    .clk        (clk),
    .rst        (rst),
    .i_clr      (acc_clr),
    .i_add      (acc_add),
    .i_max      (max_q),
    .i_min      (min_q),
    .o_range_hit(range_hit),
    .o_vpp      (avg_vpp),
    .o_offset   (avg_offset)
  );

  always_comb begin
    state_d     = state_q;
    st_d        = st_q;
    cont_d      = cont_q;
    cnt_d       = cnt_q;
    max_d       = max_q;
    min_d       = min_q;
    vpp_d       = vpp_q;
    offset_d    = offset_q;
    range_err_d = range_err_q;
    acc_clr     = 1'b0;
    acc_add     = 1'b0;
    done_fire   = 1'b0;
    start_pulse = 1'b0;
`ifdef PP_SCHED_TIMEOUT_EN
    timeout_d   = timeout_q;
    wait_limit  = {1'b0, st_q} + 33'(TIMEOUT_MARGIN) - 33'd1;
    wait_cnt_d  = (state_q == S_WAIT) ? wait_cnt_q + 33'd1 : '0;
`endif
    // Abort wins over everything; all other state simply holds.
    if (i_abort) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: if (i_arm) begin
          st_d        = (i_cfg_search_time == '0) ? 32'd1 : i_cfg_search_time;
          cont_d      = i_cfg_continuous;
          cnt_d       = '0;
          acc_clr     = 1'b1;
          range_err_d = 1'b0;
`ifdef PP_SCHED_TIMEOUT_EN
          timeout_d   = 1'b0;
`endif
          state_d     = S_START;
        end
        S_START: begin
          start_pulse = 1'b1;
          state_d     = S_WAIT;
        end
        S_WAIT: begin
          if (i_search_end_pulse) begin
            max_d   = i_search_max;
            min_d   = i_search_min;
            state_d = S_ACC;
          end
`ifdef PP_SCHED_TIMEOUT_EN
          else if (wait_cnt_q == wait_limit) begin
            timeout_d = 1'b1;
            state_d   = S_IDLE;
          end
`endif
        end
        S_ACC: begin
          acc_add = 1'b1;
          if (range_hit) range_err_d = 1'b1;
          if (cnt_q == LAST) begin
            state_d = S_DONE;
          end else begin
            cnt_d   = cnt_q + CW'(1);
            state_d = S_START;
          end
        end
        S_DONE: begin
          done_fire = 1'b1;
          vpp_d     = avg_vpp;
          offset_d  = avg_offset;
          if (cont_q) begin
            acc_clr = 1'b1;
            cnt_d   = '0;
            state_d = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      st_q        <= '0;
      cont_q      <= 1'b0;
      cnt_q       <= '0;
      max_q       <= '0;
      min_q       <= '0;
      vpp_q       <= '0;
      offset_q    <= '0;
      range_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      st_q        <= st_d;
      cont_q      <= cont_d;
      cnt_q       <= cnt_d;
      max_q       <= max_d;
      min_q       <= min_d;
      vpp_q       <= vpp_d;
      offset_q    <= offset_d;
      range_err_q <= range_err_d;
    end
  end

`ifdef PP_SCHED_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      timeout_q  <= timeout_d;
    end
  end
  assign o_timeout = timeout_q;
`else
  assign o_timeout = 1'b0;
`endif

  // Result is presented during DONE and held in vpp_q/offset_q afterwards.
  assign o_vpp                = done_fire ? avg_vpp : vpp_q;
  assign o_offset             = done_fire ? avg_offset : offset_q;
  assign o_result_valid       = done_fire;
  assign o_search_start_pulse = start_pulse;
  assign o_search_time        = st_q;
  assign o_busy               = (state_q != S_IDLE);
  assign o_range_err          = range_err_q;
endmodule

// File: doc/pp_sched.md
PP_SCHED -- requirements
Module: pp_sched

Interface
REQ-001 The block SHALL have parameter AVG_LOG2, default 2, giving 2^AVG_LOG2 search windows averaged per result.
REQ-002 The block SHALL have parameter TIMEOUT_MARGIN, default 16, giving extra cycles allowed beyond the search time before timeout.
REQ-003 The block SHALL have these ports, one clock, with synchronous active-high reset:
 clk  in  1  system clock
 rst  in  1  synchronous active-high reset
 i_cfg_search_time  in  32  samples per search window
 i_cfg_continuous  in  1  1 = re-run after each result
 i_arm  in  1  pulse, start a measurement
 i_abort  in  1  pulse, stop immediately
 o_search_start_pulse  out  1  start strobe to peak-search engine
 o_search_time  out  32  window length to engine
 i_search_max  in  32 signed  engine max result
 i_search_min  in  32 signed  engine min result
 i_search_end_pulse  in  1  engine done strobe
 o_vpp  out  33 unsigned  averaged max-min
 o_offset  out  32 signed  averaged (max+min)/2
 o_result_valid  out  1  one-cycle result strobe
 o_busy  out  1  high in any state except IDLE
 o_timeout  out  1  sticky timeout flag
 o_range_err  out  1  sticky, a window returned max<min

Function
REQ-004 The FSM SHALL have states IDLE, START, WAIT, ACC, DONE.
REQ-005 IDLE: on i_arm, the block SHALL latch i_cfg_search_time (0 replaced by 1) and i_cfg_continuous, clear the accumulators, window count and sticky flags, and go to START.
REQ-006 START: the block SHALL assert o_search_start_pulse for exactly one cycle and go to WAIT.
REQ-007 WAIT: on i_search_end_pulse, the block SHALL register i_search_max and i_search_min and go to ACC.
REQ-008 ACC: the block SHALL add (max-min), 33-bit, into the vpp accumulator and (max+min), 33-bit signed, into the mid accumulator, each 33+AVG_LOG2 bits wide and sign-correct.
REQ-009 ACC: if max<min, the block SHALL add 0 for vpp and 0 for mid, and set o_range_err.
REQ-010 ACC: the block SHALL go to DONE when the window count equals 2^AVG_LOG2-1, and otherwise increment the count and go to START.
REQ-011 DONE: the block SHALL drive o_vpp = vpp_acc >> AVG_LOG2 (truncating) and o_offset = mid_acc >>> (AVG_LOG2+1) (arithmetic, floor), and pulse o_result_valid for one cycle.
REQ-012 DONE: in continuous mode, the block SHALL clear the accumulators and go to START; otherwise it SHALL go to IDLE.
REQ-013 o_vpp and o_offset SHALL hold their values between o_result_valid pulses.
REQ-014 o_search_time SHALL show the latched value and stay constant while o_busy is high.
REQ-015 i_arm while busy SHALL be ignored.
REQ-016 i_search_end_pulse outside WAIT SHALL be ignored.
REQ-017 i_abort in any state SHALL force IDLE on the next cycle, with no o_result_valid and the result outputs unchanged; i_abort has priority over i_arm and i_search_end_pulse in the same cycle.

Reset
REQ-018 When rst is sampled high, state SHALL be IDLE, and all outputs, accumulators and counters SHALL be 0; reset mid-measurement drops the partial result.

Configuration
REQ-019 With PP_SCHED_TIMEOUT_EN defined, a WAIT counter SHALL run; when it reaches latched search_time + TIMEOUT_MARGIN without an end pulse, the block SHALL set o_timeout and go to IDLE with no result.
REQ-020 Without PP_SCHED_TIMEOUT_EN, WAIT SHALL be unbounded, no counter logic is built, and o_timeout SHALL be tied 0.

Structure
REQ-021 A shared package pp_pkg SHALL hold the state encoding (one-hot, IDLE=1, START=2, WAIT=4, ACC=8, DONE=16) and the 33-bit vpp width constant.
REQ-022 The accumulate-and-average datapath SHALL be a sub-module pp_avg_acc (clear, add, result); the FSM stays in pp_sched.

Verification
REQ-023 With AVG_LOG2=2, search_time=100, single-shot, and an engine model returning max=1000, min=-200 every window: expect 4 start pulses, then o_vpp=1200, o_offset=400, and one o_result_valid, with o_busy falling in the following cycle.
REQ-024 Windows returning (max,min) = (10,0), (11,0), (12,0), (13,0): expect o_vpp=11 (46>>2) and o_offset=5 (46>>>3).
REQ-025 Continuous mode with 3 results, then i_abort during the 2nd window of the 4th result: expect exactly 3 o_result_valid pulses, outputs holding the 3rd result, and IDLE one cycle after the abort.
REQ-026 With PP_SCHED_TIMEOUT_EN defined, search_time=50, and no end pulse: expect o_timeout=1 at 66 WAIT cycles, IDLE, no valid; the next i_arm clears o_timeout.
REQ-027 An engine returning max=-32768, min=32767: expect o_range_err=1 and that window contributing 0.
REQ-028 i_cfg_search_time=0: expect o_search_time=1. Applying i_arm and i_search_end_pulse while busy or out of WAIT: expect no effect.
